// File: rtl/conv_row_reader.sv
// rtl/conv_row_reader.sv - captures a ROWS x ROW_W result matrix and presents it one row at a time
// Rows are stepped by a synchronised, edge-detected switch input; all outputs are registered.
module conv_row_reader #(
    parameter int ROWS  = 6,
    parameter int ROW_W = 6,
    parameter int IDX_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  result_valid,
    input  logic [ROWS*ROW_W-1:0] result_flat,
    input  logic                  next_row,
    output logic [ROW_W-1:0]      out_row,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_valid,
    output logic                  done,
    output logic                  overrun
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SHOW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

    state_t                state;
    logic [ROWS*ROW_W-1:0] buffer;
    logic                  sync1;
    logic                  sync2;
    logic                  hist;
    logic                  adv;
    logic [IDX_W-1:0]      next_idx;

    // One advance per rising edge of the synchronised switch level.
    assign adv      = sync2 & ~hist;
    assign next_idx = out_idx + IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            buffer    <= '0;
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            hist      <= 1'b0;
            out_row   <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sync1 <= next_row;
            sync2 <= sync1;
            hist  <= sync2;
            case (state)
                S_IDLE, S_DONE: begin
                    if (result_valid) begin
                        buffer    <= result_flat;
                        out_row   <= result_flat[ROW_W-1:0];
                        out_idx   <= '0;
                        out_valid <= 1'b1;
                        done      <= 1'b0;
                        state     <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    // A new result mid read-out is dropped; the buffer keeps the old matrix.
                    if (result_valid) begin
                        overrun <= 1'b1;
                    end
                    if (adv) begin
                        if (out_idx == LAST_IDX) begin
                            state     <= S_DONE;
                            out_valid <= 1'b0;
                            out_row   <= '0;
                            out_idx   <= '0;
                            done      <= 1'b1;
                        end else begin
                            out_idx <= next_idx;
                            out_row <= buffer[int'(next_idx)*ROW_W +: ROW_W];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_row_reader.sv
// tb/tb_conv_row_reader.sv - self-checking bench for conv_row_reader
// Behavioural model plus per-cycle compare, pinned by literal checks at key points.
module tb_conv_row_reader;

    localparam int ROWS  = 6;
    localparam int ROW_W = 6;
    localparam int IDX_W = 3;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  result_valid = 1'b0;
    logic [ROWS*ROW_W-1:0] result_flat = '0;
    logic                  next_row = 1'b0;
    logic [ROW_W-1:0]      out_row;
    logic [IDX_W-1:0]      out_idx;
    logic                  out_valid;
    logic                  done;
    logic                  overrun;

    int checks = 0;
    int failures = 0;

    conv_row_reader #(.ROWS(ROWS), .ROW_W(ROW_W), .IDX_W(IDX_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .result_valid(result_valid),
        .result_flat(result_flat),
        .next_row(next_row),
        .out_row(out_row),
        .out_idx(out_idx),
        .out_valid(out_valid),
        .done(done),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle / 1 showing / 2 finished; p1..p3 are next_row samples at the last three edges.
    int         m_mode = 0;
    int         m_idx = 0;
    bit         m_over = 0;
    bit         p1 = 0, p2 = 0, p3 = 0;
    bit         m_adv;
    logic [5:0] mat [ROWS];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_idx = 0; m_over = 0;
            p1 = 0; p2 = 0; p3 = 0;
        end else begin
            m_adv = p2 && !p3;
            p3 = p2; p2 = p1; p1 = next_row;
            if (m_mode == 1) begin
                if (result_valid) m_over = 1;
                if (m_adv) begin
                    if (m_idx == ROWS - 1) m_mode = 2;
                    else m_idx = m_idx + 1;
                end
            end else if (result_valid) begin
                for (int r = 0; r < ROWS; r++) mat[r] = result_flat[r*ROW_W +: ROW_W];
                m_mode = 1;
                m_idx  = 0;
            end
        end
    end

    function automatic logic [ROW_W+IDX_W+2:0] model_out();
        logic [ROW_W-1:0] row;
        logic [IDX_W-1:0] idx;
        row = (m_mode == 1) ? mat[m_idx] : '0;
        idx = (m_mode == 1) ? IDX_W'(m_idx) : '0;
        return {row, idx, m_mode == 1, m_mode == 2, m_over};
    endfunction

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            checks++;
            if ({out_row, out_idx, out_valid, done, overrun} !== model_out()) begin
                failures++;
                $display("FAIL cycle_compare t=%0t got row=%h idx=%0d valid=%b done=%b ovr=%b expected %h",
                         $time, out_row, out_idx, out_valid, done, overrun, model_out());
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input int row, input int idx, input int v, input int d, input int o);
        chk({name, "_row"}, int'(out_row), row);
        chk({name, "_idx"}, int'(out_idx), idx);
        chk({name, "_valid"}, int'(out_valid), v);
        chk({name, "_done"}, int'(done), d);
        chk({name, "_overrun"}, int'(overrun), o);
    endtask

    task automatic load(input logic [ROWS*ROW_W-1:0] m);
        @(negedge clk);
        result_flat  = m;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        result_flat  = {ROWS{6'h15}};
    endtask

    task automatic step();
        @(negedge clk) next_row = 1'b1;
        @(negedge clk);
        @(negedge clk) next_row = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    logic [ROWS*ROW_W-1:0] mat_a, mat_b, mat_f;

    initial begin
        mat_a = {6'h06, 6'h05, 6'h04, 6'h03, 6'h02, 6'h01};
        mat_b = {6'h01, 6'h33, 6'h0C, 6'h15, 6'h2A, 6'h3F};
        mat_f = {ROWS{6'h3F}};

        // Reset with inputs toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            result_valid = i[0];
            next_row     = ~i[0];
            result_flat  = {ROWS{6'(i * 7)}};
        end
        chk_all("in_reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        result_valid = 1'b0;
        next_row     = 1'b0;
        rst_n        = 1'b1;
        repeat (5) @(negedge clk);
        chk_all("after_release", 0, 0, 0, 0, 0);

        // Load and step through all rows
        load(mat_a);
        chk_all("load_a", 1, 0, 1, 0, 0);
        for (int i = 1; i < ROWS; i++) begin
            step();
            chk("step_row", int'(out_row), i + 1);
            chk("step_idx", int'(out_idx), i);
        end
        step();
        chk_all("done_a", 0, 0, 0, 1, 0);

        // Reload from DONE
        load(mat_b);
        chk_all("reload_b", 6'h3F, 0, 1, 0, 0);

        // Long hold gives exactly one advance
        @(negedge clk) next_row = 1'b1;
        repeat (20) @(negedge clk);
        next_row = 1'b0;
        repeat (4) @(negedge clk);
        chk_all("long_hold", 6'h2A, 1, 1, 0, 0);

        // Overrun at idx 2, old rows remain
        step();
        load(mat_f);
        chk_all("overrun", 6'h15, 2, 1, 0, 1);
        step();
        chk("ovr_row3", int'(out_row), 6'h0C);
        step();
        chk("ovr_row4", int'(out_row), 6'h33);
        step();
        chk("ovr_row5", int'(out_row), 6'h01);
        step();
        chk_all("ovr_done", 0, 0, 0, 1, 1);

        // Reset mid read-out
        load(mat_a);
        step(); step(); step();
        chk("pre_reset_idx", int'(out_idx), 3);
        #2 rst_n = 1'b0;
        #1 chk_all("async_reset", 0, 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk_all("post_reset", 0, 0, 0, 0, 0);

        // Result coincident with an advance
        load(mat_b);
        chk_all("load_b2", 6'h3F, 0, 1, 0, 0);
        @(negedge clk) next_row = 1'b1;
        @(negedge clk);
        @(negedge clk);
        result_flat  = mat_f;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        next_row     = 1'b0;
        repeat (3) @(negedge clk);
        chk_all("coincident", 6'h2A, 1, 1, 0, 1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
